// File: rtl/csa_pkg.sv
// csa_pkg: shared types and constants for the nine-operand CSA sequencer.
package csa_pkg;
    typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;
    localparam int OP_W = 16;
    localparam int SUM_W = 20;
    localparam int N_OPS = 9;
    localparam logic [SUM_W-1:0] MAX_SUM = 20'h8FFF7;
endpackage

// File: rtl/csa_operand_sequencer_if.sv
// csa_operand_sequencer_if: operand input stream and result output stream.
interface csa_operand_sequencer_if;
    import csa_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [OP_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [SUM_W-1:0] out_sum;
    logic out_cout;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_sum, out_cout);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_sum, out_cout);
endinterface

// File: rtl/csa_operand_sequencer_bank.sv
// operand_bank: nine operand registers written one at a time by index.
module operand_bank
    import csa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic [3:0] idx,
    input  logic [OP_W-1:0] d,
    output logic [N_OPS-1:0][OP_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else for (int i = 0; i < N_OPS; i++) if (we && idx == 4'(i)) q[i] <= d;
    end
endmodule

// File: rtl/csa_operand_sequencer.sv
// csa_operand_sequencer: loads nine operands for the external CSA tree and
// captures its result after one settle cycle, returning it over a stream.
module csa_operand_sequencer
    import csa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    csa_operand_sequencer_if.slave s,
    output logic [OP_W-1:0] op1,
    output logic [OP_W-1:0] op2,
    output logic [OP_W-1:0] op3,
    output logic [OP_W-1:0] op4,
    output logic [OP_W-1:0] op5,
    output logic [OP_W-1:0] op6,
    output logic [OP_W-1:0] op7,
    output logic [OP_W-1:0] op8,
    output logic [OP_W-1:0] op9,
    input  logic [SUM_W-1:0] adder_sum,
    input  logic adder_cout,
    output logic busy,
    output logic [3:0] count
);
    state_t state;
    logic [N_OPS-1:0][OP_W-1:0] ops;
    logic we;

    // in_ready is registered high exactly while in LOAD, so it gates nothing extra here
    assign we = state == LOAD && s.in_valid;

    operand_bank bank (.clk(clk), .rst(rst), .we(we), .idx(count), .d(s.in_data), .q(ops));

    assign {op9, op8, op7, op6, op5, op4, op3, op2, op1} = ops;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            count <= '0;
            s.out_sum <= '0;
            s.out_cout <= 1'b0;
            s.in_ready <= 1'b1;
            s.out_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                LOAD: if (s.in_valid) begin
                    count <= count + 4'd1;
                    if (count == 4'(N_OPS - 1)) begin
                        state <= CALC;
                        s.in_ready <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                CALC: begin
                    s.out_sum <= adder_sum;
                    s.out_cout <= adder_cout;
                    s.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (s.out_ready) begin
                    state <= LOAD;
                    count <= '0;
                    s.out_valid <= 1'b0;
                    s.in_ready <= 1'b1;
                    busy <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_operand_sequencer.sv
// tb_csa_operand_sequencer: directed bench with a behavioural adder tree.
module tb_csa_operand_sequencer;
    import csa_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N_OPS-1:0][OP_W-1:0] ops;
    logic [SUM_W:0] acc;
    logic [SUM_W-1:0] adder_sum;
    logic adder_cout;
    logic busy;
    logic [3:0] count;
    int n_cmp = 0;
    int n_err = 0;

    csa_operand_sequencer_if bus();

    csa_operand_sequencer dut (
        .clk(clk), .rst(rst), .s(bus),
        .op1(ops[0]), .op2(ops[1]), .op3(ops[2]), .op4(ops[3]), .op5(ops[4]),
        .op6(ops[5]), .op7(ops[6]), .op8(ops[7]), .op9(ops[8]),
        .adder_sum(adder_sum), .adder_cout(adder_cout), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N_OPS; i++) acc = acc + (SUM_W+1)'(ops[i]);
    end
    assign adder_sum = acc[SUM_W-1:0];
    assign adder_cout = acc[SUM_W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OP_W-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_data = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load9(input logic [OP_W-1:0] v);
        for (int i = 0; i < N_OPS; i++) send(v);
    endtask

    // called right after the ninth handshake, with out_ready already high
    task automatic finish_batch(input string tag, input logic [SUM_W-1:0] exp);
        check({tag, "_calc_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_calc_busy"}, 32'(busy), 1);
        check({tag, "_calc_ready"}, 32'(bus.in_ready), 0);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_sum"}, 32'(bus.out_sum), 32'(exp));
        check({tag, "_cout"}, 32'(bus.out_cout), 0);
        check({tag, "_count9"}, 32'(count), 9);
        tick();
        check({tag, "_released"}, 32'(bus.out_valid), 0);
        check({tag, "_count0"}, 32'(count), 0);
        check({tag, "_ready"}, 32'(bus.in_ready), 1);
        check({tag, "_hold"}, 32'(bus.out_sum), 32'(exp));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(bus.out_sum), 0);
        check("rst_ops", 32'(adder_sum), 0);
        tick();
        check("rst_ready", 32'(bus.in_ready), 1);

        load9(16'd1);
        finish_batch("basic", 20'd9);

        load9(16'hFFFF);
        finish_batch("max", MAX_SUM);

        for (int i = 1; i <= 9; i++) begin
            send(16'(i));
            if (i == 4) for (int g = 0; g < 3; g++) begin
                tick();
                check("gap_count", 32'(count), 4);
            end
        end
        check("order_op1", 32'(ops[0]), 1);
        check("order_op9", 32'(ops[8]), 9);
        finish_batch("gap", 20'd45);

        bus.out_ready = 1'b0;
        load9(16'd5);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.in_data = 16'h1234;
            end
            tick();
            bus.in_valid = 1'b0;
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_sum", 32'(bus.out_sum), 45);
            check("bp_ready", 32'(bus.in_ready), 0);
            check("bp_count", 32'(count), 9);
        end
        check("bp_op1", 32'(ops[0]), 5);
        bus.out_ready = 1'b1;
        tick();
        check("bp_release", 32'(bus.out_valid), 0);

        for (int i = 0; i < 5; i++) send(16'd7);
        check("mid_count5", 32'(count), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_count", 32'(count), 0);
        check("mid_valid", 32'(bus.out_valid), 0);
        check("mid_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < N_OPS; i++) check("mid_op", 32'(ops[i]), 0);
        load9(16'h0010);
        finish_batch("mid", 20'h90);

        load9(16'd2);
        tick();
        check("b1_sum", 32'(bus.out_sum), 18);
        bus.in_valid = 1'b1;
        bus.in_data = 16'd3;
        tick();
        check("b2_no_overlap", 32'(count), 0);
        tick();
        check("b2_first", 32'(count), 1);
        for (int i = 0; i < 8; i++) send(16'd3);
        finish_batch("b2", 20'd27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
